// File: rtl/gray_counter.sv
// Synchronous up/down counter with registered binary and Gray outputs and a wrap pulse.
// Loadable from a binary or Gray-coded value; Gray loads are decoded to binary internally.
module gray_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ResetBin  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ResetGray = ResetBin ^ (ResetBin >> 1);
  localparam logic [WIDTH-1:0] One       = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_bin;

  // Binary bit i is the XOR of all Gray bits from the MSB down to i.
  always_comb begin
    load_bin = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      load_bin[i] = ^(load_val >> i);
    end
  end

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_is_gray ? load_bin : load_val;
    end else if (en) begin
      if (up_dn) begin
        bin_d  = bin_q + One;
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - One;
        wrap_d = ~|bin_q;
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= ResetBin;
      gray_q <= ResetGray;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed steps from the test plan, then random
// stimulus checked against an arithmetic reference model.
module tb_gray_counter;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst, en, up_dn, load, load_is_gray;
  logic [W-1:0] load_val;
  logic [W-1:0] bin_out, gray_out;
  logic         wrap;

  int errors = 0;
  int checks = 0;
  int m_bin  = 0;
  bit m_wrap = 0;

  gray_counter #(.WIDTH(W), .RESET_VAL(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .up_dn        (up_dn),
    .load         (load),
    .load_is_gray (load_is_gray),
    .load_val     (load_val),
    .bin_out      (bin_out),
    .gray_out     (gray_out),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  function automatic int to_gray(int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(int g);
    int b = 0;
    for (int s = g; s != 0; s = s >> 1) b = b ^ s;
    return b;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare all outputs to the model.
  task automatic cyc(bit r, bit e, bit u, bit l, bit lg, int lv);
    rst = r; en = e; up_dn = u; load = l; load_is_gray = lg; load_val = W'(lv);
    @(posedge clk);
    if (r) begin
      m_bin = 0; m_wrap = 0;
    end else if (l) begin
      m_bin = lg ? from_gray(lv % M) : lv % M; m_wrap = 0;
    end else if (e) begin
      if (u) begin m_wrap = (m_bin == M - 1); m_bin = (m_bin + 1) % M; end
      else   begin m_wrap = (m_bin == 0);     m_bin = (m_bin + M - 1) % M; end
    end else begin
      m_wrap = 0;
    end
    #1;
    chk("model_bin", int'(bin_out), m_bin);
    chk("model_gray", int'(gray_out), to_gray(m_bin));
    chk("model_wrap", int'(wrap), int'(m_wrap));
  endtask

  initial begin
    int up_seq[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    int ld_bin[5]  = '{8, 12, 14, 9, 10};
    int ld_gray[5] = '{12, 10, 9, 13, 15};
    int prev;

    // Reset with en and load both high.
    cyc(1, 1, 1, 1, 0, 5);
    cyc(1, 1, 1, 1, 0, 5);
    chk("reset_bin", int'(bin_out), 0);
    chk("reset_gray", int'(gray_out), 0);
    chk("reset_wrap", int'(wrap), 0);

    // Full up-count cycle.
    prev = int'(gray_out);
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 1, 0, 0, 0);
      chk("up_gray_seq", int'(gray_out), up_seq[i % 16]);
      chk("up_hamming", $countones(W'(prev) ^ gray_out), 1);
      chk("up_wrap", int'(wrap), (i == 16) ? 1 : 0);
      prev = int'(gray_out);
    end

    // Down count through zero.
    cyc(0, 1, 0, 0, 0, 0);
    chk("down_wrap_bin", int'(bin_out), 15);
    chk("down_wrap_gray", int'(gray_out), 8);
    chk("down_wrap_pulse", int'(wrap), 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("down_next_bin", int'(bin_out), 14);
    chk("down_next_gray", int'(gray_out), 9);
    chk("down_next_wrap", int'(wrap), 0);

    // Binary loads.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 1, 0, ld_bin[i]);
      chk("bin_load_gray", int'(gray_out), ld_gray[i]);
    end

    // Gray load beats en.
    cyc(0, 1, 1, 1, 1, 14);
    chk("gray_load_bin", int'(bin_out), 11);
    chk("gray_load_gray", int'(gray_out), 14);
    chk("gray_load_wrap", int'(wrap), 0);
    cyc(0, 1, 1, 1, 0, 15);
    chk("load15_wrap", int'(wrap), 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("load15_up_bin", int'(bin_out), 0);
    chk("load15_up_wrap", int'(wrap), 1);

    // Hold at 6.
    cyc(0, 0, 1, 1, 0, 6);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      chk("hold_bin", int'(bin_out), 6);
      chk("hold_wrap", int'(wrap), 0);
    end

    // Reset mid-count, then resume.
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    chk("midrst_bin", int'(bin_out), 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("resume_bin1", int'(bin_out), 1);
    cyc(0, 1, 1, 0, 0, 0);
    chk("resume_bin2", int'(bin_out), 2);

    // Randomized stimulus; count steps must also change exactly one Gray bit.
    for (int i = 0; i < 400; i++) begin
      bit r, e, u, l, lg;
      int lv;
      r  = ($urandom_range(0, 31) == 0);
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1) == 1;
      lg = $urandom_range(0, 1) == 1;
      lv = int'($urandom_range(0, M - 1));
      prev = int'(gray_out);
      cyc(r, e, u, l, lg, lv);
      if (!r && !l && e) chk("rand_hamming", $countones(W'(prev) ^ gray_out), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
